// File: rtl/devil_snoop_delay_inj.sv
// ACE snoop-channel (AC/CR) fault injector: queues snoops in order and answers each on CR,
// delaying filtered snoops with a programmed CRRESP. Optional capture of the last triggered snoop: DEVIL_CAPTURE_EN.
module devil_snoop_delay_inj #(
  parameter int ADDR_W  = 44,
  parameter int N_WIN   = 4,
  parameter int DEPTH   = 8,
  parameter int DELAY_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    acvalid,
  output logic                    acready,
  input  logic [ADDR_W-1:0]       acaddr,
  input  logic [3:0]              acsnoop,
  output logic                    crvalid,
  input  logic                    crready,
  output logic [4:0]              crresp,
  input  logic                    cfg_en,
  input  logic                    cfg_mode,
  input  logic [DELAY_W-1:0]      cfg_delay,
  input  logic [4:0]              cfg_crresp,
  input  logic                    cfg_acflt_en,
  input  logic [3:0]              cfg_acsnoop,
  input  logic                    cfg_addrflt_en,
  input  logic [N_WIN-1:0]        cfg_win_en,
  input  logic [N_WIN*ADDR_W-1:0] cfg_win_base,
  input  logic [N_WIN*ADDR_W-1:0] cfg_win_size,
  input  logic                    sts_done_clr,
  output logic                    sts_done,
  output logic                    sts_busy,
  output logic [31:0]             sts_hit_cnt,
  output logic [ADDR_W-1:0]       sts_last_addr,
  output logic [3:0]              sts_last_snoop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t               state, state_nx;
  logic [DELAY_W-1:0]   cnt, cnt_nx;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
  logic [PTR_W:0]       count;
  logic                 mem_trig  [DEPTH];
  logic [4:0]           mem_resp  [DEPTH];
  logic [DELAY_W-1:0]   mem_delay [DEPTH];
  logic                 armed, cfg_en_q;
  logic [N_WIN-1:0]     win_hit;
  logic [ADDR_W:0]      w_base, w_end;
  logic                 typ_ok, addr_ok, trig;
  logic                 push, pop, push_trig, pop_trig;
  logic [DELAY_W-1:0]   ld_delay;

  // Window bounds are widened by one bit so base+size never wraps into low addresses.
  always_comb begin
    win_hit = '0;
    w_base  = '0;
    w_end   = '0;
    for (int unsigned i = 0; i < N_WIN; i++) begin
      w_base = {1'b0, cfg_win_base[i*ADDR_W +: ADDR_W]};
      w_end  = w_base + {1'b0, cfg_win_size[i*ADDR_W +: ADDR_W]};
      win_hit[i] = cfg_win_en[i] && (cfg_win_size[i*ADDR_W +: ADDR_W] != '0) &&
                   (w_base <= {1'b0, acaddr}) && ({1'b0, acaddr} < w_end);
    end
  end

  assign typ_ok    = !cfg_acflt_en || (acsnoop == cfg_acsnoop);
  assign addr_ok   = !cfg_addrflt_en || (|win_hit);
  assign trig      = cfg_en && armed && typ_ok && addr_ok;

  assign acready   = !reset && (count < DEPTH_C);
  assign push      = acvalid && acready;
  assign pop       = (state == S_RESP) && crready;
  assign push_trig = push && trig;
  assign pop_trig  = pop && mem_trig[rd_ptr];
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  assign crvalid   = (state == S_RESP);
  assign crresp    = (state == S_RESP) ? mem_resp[rd_ptr] : '0;
  assign sts_busy  = (count != '0) || (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_trig[wr_ptr]  <= trig;
      mem_resp[wr_ptr]  <= trig ? cfg_crresp : '0;
      mem_delay[wr_ptr] <= trig ? cfg_delay : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Counter is loaded with delay-1 so a snoop accepted into an empty FIFO shows crvalid 1+delay cycles later.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_delay = (state == S_RESP) ? mem_delay[rd_ptr_inc] : mem_delay[rd_ptr];
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          if (ld_delay == '0) begin
            state_nx = S_RESP;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = ld_delay - DELAY_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nx = S_RESP;
        else           cnt_nx   = cnt - DELAY_W'(1);
      end
      S_RESP: begin
        if (crready) begin
          if (count > (PTR_W+1)'(1)) begin
            if (ld_delay == '0) begin
              state_nx = S_RESP;
            end else begin
              state_nx = S_WAIT;
              cnt_nx   = ld_delay - DELAY_W'(1);
            end
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // One-shot disarms on the first trig push (and again on its pop); disarm beats re-arm in one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed       <= 1'b1;
      cfg_en_q    <= 1'b0;
      sts_done    <= 1'b0;
      sts_hit_cnt <= '0;
    end else begin
      cfg_en_q <= cfg_en;
      if ((push_trig || pop_trig) && !cfg_mode)      armed <= 1'b0;
      else if (sts_done_clr || (cfg_en && !cfg_en_q)) armed <= 1'b1;
      if (pop_trig)          sts_done <= 1'b1;
      else if (sts_done_clr) sts_done <= 1'b0;
      if (pop_trig && (sts_hit_cnt != '1)) sts_hit_cnt <= sts_hit_cnt + 32'd1;
    end
  end

`ifdef DEVIL_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sts_last_addr  <= '0;
      sts_last_snoop <= '0;
    end else if (push_trig) begin
      sts_last_addr  <= acaddr;
      sts_last_snoop <= acsnoop;
    end
  end
`else
  assign sts_last_addr  = '0;
  assign sts_last_snoop = '0;
`endif

endmodule
